pic_tmr_wdt: RTL

Timer0 clock-source/prescaler and watchdog-timer block for the PIC16F54 core. It consumes the core's OPTION register value, the CLRWDT, SLEEP and TMR0-write strobes, and the external T0CKI pin. It produces the `tmr0_inc` count-enable and the `wdtmr` timeout that the core's register file samples. It sits beside the core and holds the single 8-bit prescaler shared between TMR0 and the WDT.

---
 rtl/pic_tmr_wdt.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pic_tmr_wdt.sv
// pic_tmr_wdt: TMR0 clock source, shared prescaler and watchdog timer.
// Define PIC_TMR_WDT_WDT_EN to build in the watchdog timer.
module pic_tmr_wdt #(
  parameter int WDT_PERIOD = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] option_in,
  input  logic       t0cki,
  input  logic       tmr0_wr,
  input  logic       clrwdt,
  input  logic       sleep,
  input  logic       wake,
  output logic       tmr0_inc,
  output logic       wdtmr,
  output logic       sleeping
);

  logic       t0cs;
  logic       t0se;
  logic       psa;
  logic [2:0] ps;

  assign t0cs = option_in[5];
  assign t0se = option_in[4];
  assign psa  = option_in[3];
  assign ps   = option_in[2:0];

  logic [7:0] p;
  logic       s1;
  logic       s2;
  logic       s_prev;
  logic       psa_q;
  logic [1:0] warm;

  logic [7:0] tmask;
  logic [7:0] wmask;
  logic       edge_ok;
  logic       rise;
  logic       fall;
  logic       ev;
  logic       clr_p;
  logic       clr_b;
  logic       tall;
  logic       wall;
  logic       wdt_to;
  logic       wdt_inc;

  // TMR0 divides by 2^(PS+1), the WDT by 2^PS
  assign tmask = 8'hff >> (3'd7 - ps);
  assign wmask = 8'hff >> (4'd8 - {1'b0, ps});
  assign tall  = (p & tmask) == tmask;
  assign wall  = (p & wmask) == wmask;

  assign edge_ok = warm == 2'd3;
  assign rise    = s2 & ~s_prev;
  assign fall    = ~s2 & s_prev;
  assign ev      = t0cs ? (edge_ok & (t0se ? fall : rise))
                        : ~sleeping;

  assign clr_p = (psa ^ psa_q)
               | (tmr0_wr & ~psa)
               | (psa & (sleep | clr_b));

`ifdef PIC_TMR_WDT_WDT_EN
  localparam logic [15:0] BMAX = 16'(WDT_PERIOD - 1);

  logic [15:0] b;
  logic        tick;

  assign clr_b   = clrwdt | sleep;
  assign tick    = (b == BMAX) & ~clr_b;
  assign wdt_to  = tick & (~psa | (~clr_p & wall));
  assign wdt_inc = tick & psa;

  always_ff @(posedge clk) begin
    if (!rst) begin
      b <= '0;
    end else if (clr_b || b == BMAX) begin
      b <= '0;
    end else begin
      b <= b + 16'd1;
    end
  end
`else
  logic unused_wdt;

  assign unused_wdt = ^{clrwdt, 16'(WDT_PERIOD), wall};
  assign clr_b      = 1'b0;
  assign wdt_to     = 1'b0;
  assign wdt_inc    = 1'b0;
`endif

  logic unused_opt;

  assign unused_opt = ^option_in[7:6];

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s_prev   <= 1'b0;
      warm     <= 2'd0;
      p        <= 8'd0;
      tmr0_inc <= 1'b0;
      wdtmr    <= 1'b0;
      sleeping <= 1'b0;
      psa_q    <= psa;
    end else begin
      s1     <= t0cki;
      s2     <= s1;
      s_prev <= s2;
      psa_q  <= psa;
      if (!edge_ok) begin
        warm <= warm + 2'd1;
      end
      tmr0_inc <= psa ? ev : (ev & tall & ~clr_p);
      wdtmr    <= wdt_to;
      sleeping <= (sleeping | sleep) & ~wake & ~wdt_to;
      if (clr_p) begin
        p <= 8'd0;
      end else if (psa ? wdt_inc : ev) begin
        p <= p + 8'd1;
      end
    end
  end

endmodule
